// File: rtl/mux_arb_ctrl_tarea34_pkg.sv
// Shared definitions for the two-source round-robin mux arbiter:
// FSM state encodings and default sizing.
package mux_arb_ctrl_tarea34_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   localparam int DATA_W_DEF    = 2;
   localparam int BURST_MAX_DEF = 4;
   localparam int CNT_W_DEF     = 3;

endpackage

// File: rtl/mux_arb_ctrl_tarea34_grant.sv
// Combinational grant decision: who may use the mux this cycle, given the
// current owner, its burst length so far and who was served last.
module arb_grant_tarea34
   import mux_arb_ctrl_tarea34_pkg::*;
#(
   parameter int BURST_MAX = BURST_MAX_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic [1:0]       state,
   input  logic [CNT_W-1:0] burst_cnt,
   input  logic             last_served,
   input  logic             valid_in0,
   input  logic             valid_in1,
   output logic             grant_valid,
   output logic             grant_idx
);

   logic burst_open;

   assign burst_open = (burst_cnt < CNT_W'(BURST_MAX));

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      case (state)
         ST_OWN0: begin
            if (valid_in0 && (burst_open || !valid_in1)) begin
               grant_valid = 1'b1;
               grant_idx   = 1'b0;
            end else if (valid_in1) begin
               grant_valid = 1'b1;
               grant_idx   = 1'b1;
            end
         end
         ST_OWN1: begin
            if (valid_in1 && (burst_open || !valid_in0)) begin
               grant_valid = 1'b1;
               grant_idx   = 1'b1;
            end else if (valid_in0) begin
               grant_valid = 1'b1;
               grant_idx   = 1'b0;
            end
         end
         default: begin
            // No owner: ties go to whoever was not served last.
            if (valid_in0 && valid_in1) begin
               grant_valid = 1'b1;
               grant_idx   = !last_served;
            end else if (valid_in0 || valid_in1) begin
               grant_valid = 1'b1;
               grant_idx   = valid_in1;
            end
         end
      endcase
   end

endmodule

// File: rtl/mux_arb_ctrl_tarea34.sv
// Two-source round-robin arbiter driving a registered 2:1 mux, with bounded
// bursts, downstream pause and zero-forced output when idle or in reset.
module mux_arb_ctrl_tarea34
   import mux_arb_ctrl_tarea34_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in0,
   input  logic [DATA_W-1:0] data_in0,
   output logic              ready0,
   input  logic              valid_in1,
   input  logic [DATA_W-1:0] data_in1,
   output logic              ready1,
   input  logic              pause,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              selector
);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic              last_served_q, last_served_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_out_q, valid_out_d;
   logic              selector_q, selector_d;

   logic              grant_valid, grant_idx;
   logic              transfer, same_owner;
   logic [DATA_W-1:0] mux_data;

   arb_grant_tarea34 #(
      .BURST_MAX (BURST_MAX),
      .CNT_W     (CNT_W)
   ) u_grant (
      .state       (state_q),
      .burst_cnt   (burst_cnt_q),
      .last_served (last_served_q),
      .valid_in0   (valid_in0),
      .valid_in1   (valid_in1),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // A grant always implies the granted source is valid, so it doubles as the handshake.
   assign transfer   = grant_valid && !pause && !reset;
   assign ready0     = transfer && !grant_idx;
   assign ready1     = transfer &&  grant_idx;
   assign mux_data   = grant_idx ? data_in1 : data_in0;
   assign same_owner = (state_q == ST_OWN0 && !grant_idx) || (state_q == ST_OWN1 && grant_idx);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         burst_cnt_q   <= '0;
         last_served_q <= 1'b1;
         data_out_q    <= '0;
         valid_out_q   <= 1'b0;
         selector_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         burst_cnt_q   <= burst_cnt_d;
         last_served_q <= last_served_d;
         data_out_q    <= data_out_d;
         valid_out_q   <= valid_out_d;
         selector_q    <= selector_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      burst_cnt_d   = burst_cnt_q;
      last_served_d = last_served_q;
      if (!pause) begin
         if (transfer) begin
            state_d       = grant_idx ? ST_OWN1 : ST_OWN0;
            last_served_d = grant_idx;
            if (!same_owner)
               burst_cnt_d = CNT_W'(1);
            else if (burst_cnt_q >= CNT_W'(BURST_MAX))
               burst_cnt_d = CNT_W'(BURST_MAX);
            else
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
         end else begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
         end
      end
   end

   always_comb begin
      data_out_d  = data_out_q;
      valid_out_d = valid_out_q;
      selector_d  = selector_q;
      if (!pause) begin
         valid_out_d = transfer;
         data_out_d  = transfer ? mux_data : '0;
         if (transfer)
            selector_d = grant_idx;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign selector  = selector_q;

endmodule

// File: tb/tb_mux_arb_ctrl_tarea34.sv
// Bench for the round-robin mux arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the arbitration rules.
module tb_mux_arb_ctrl_tarea34;

   localparam int DW = 2;
   localparam int BM = 4;
   localparam int CW = 3;

   logic          clk;
   logic          reset, pause, valid_in0, valid_in1;
   logic [DW-1:0] data_in0, data_in1;
   logic          ready0, ready1, valid_out, selector;
   logic [DW-1:0] data_out;

   int checks   = 0;
   int failures = 0;

   // behavioural model: owner is -1 when nobody owns the mux
   int            m_owner, m_run, m_last, m_g;
   logic [DW-1:0] m_dout;
   logic          m_vout, m_sel, exp_r0, exp_r1;

   mux_arb_ctrl_tarea34 #(.DATA_W(DW), .BURST_MAX(BM), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in0 (valid_in0),
      .data_in0  (data_in0),
      .ready0    (ready0),
      .valid_in1 (valid_in1),
      .data_in1  (data_in1),
      .ready1    (ready1),
      .pause     (pause),
      .data_out  (data_out),
      .valid_out (valid_out),
      .selector  (selector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_grant(input logic v0, input logic v1);
      logic vv [2];
      vv[0] = v0;
      vv[1] = v1;
      if (!v0 && !v1) return -1;
      if (m_owner < 0) begin
         if (v0 && v1) return 1 - m_last;
         return v0 ? 0 : 1;
      end
      if (vv[m_owner] && (m_run < BM || !vv[1 - m_owner])) return m_owner;
      if (vv[1 - m_owner]) return 1 - m_owner;
      return -1;
   endfunction

   task automatic drive(input logic r, input logic p, input logic v0, input logic v1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      @(negedge clk);
      reset = r; pause = p; valid_in0 = v0; valid_in1 = v1; data_in0 = d0; data_in1 = d1;
      m_g    = model_grant(v0, v1);
      exp_r0 = (m_g == 0) && !p && !r;
      exp_r1 = (m_g == 1) && !p && !r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_owner = -1; m_run = 0; m_last = 1; m_dout = '0; m_vout = 1'b0; m_sel = 1'b0;
      end else if (!pause) begin
         if (m_g >= 0) begin
            m_run   = (m_g == m_owner) ? ((m_run + 1 > BM) ? BM : m_run + 1) : 1;
            m_owner = m_g;
            m_last  = m_g;
            m_vout  = 1'b1;
            m_dout  = (m_g == 1) ? data_in1 : data_in0;
            m_sel   = (m_g == 1);
         end else begin
            m_owner = -1; m_run = 0; m_vout = 1'b0; m_dout = '0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, '0, '0);
      tick();
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, 1, 1, 2'b11, 2'b11);
         checks++;
         if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", ready0, ready1);
         end
         tick();
         checks++;
         if (data_out !== 2'b00 || valid_out !== 1'b0 || selector !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got d=%b v=%b s=%b want 00 0 0", data_out, valid_out, selector);
         end
      end
   endtask

   task automatic test_single();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 0, 2'b10, 2'b01);
         checks++;
         if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
            failures++;
            $display("FAIL single_ready[%0d]: got r0=%b r1=%b want 1 0", k, ready0, ready1);
         end
         tick();
         checks++;
         if (data_out !== 2'b10 || valid_out !== 1'b1 || selector !== 1'b0) begin
            failures++;
            $display("FAIL single_out[%0d]: got d=%b v=%b s=%b want 10 1 0", k, data_out, valid_out, selector);
         end
      end
   endtask

   task automatic test_burst();
      logic          s;
      logic [DW-1:0] d;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         drive(0, 0, 1, 1, 2'b01, 2'b10);
         tick();
         s = ((k / BM) % 2) == 1;
         d = s ? 2'b10 : 2'b01;
         checks++;
         if (selector !== s || valid_out !== 1'b1 || data_out !== d) begin
            failures++;
            $display("FAIL burst[%0d]: got s=%b v=%b d=%b want s=%b v=1 d=%b", k, selector, valid_out, data_out, s, d);
         end
      end
   endtask

   task automatic test_tie();
      do_reset();
      drive(0, 0, 0, 1, 2'b00, 2'b11); tick();
      drive(0, 0, 0, 0, 2'b00, 2'b00); tick();
      checks++;
      if (valid_out !== 1'b0 || data_out !== 2'b00 || selector !== 1'b1) begin
         failures++;
         $display("FAIL tie_idle: got v=%b d=%b s=%b want 0 00 1", valid_out, data_out, selector);
      end
      drive(0, 0, 1, 1, 2'b01, 2'b11);
      checks++;
      if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
         failures++;
         $display("FAIL tie_after_src1: got r0=%b r1=%b want 1 0", ready0, ready1);
      end
      tick();
      drive(0, 0, 0, 0, 2'b00, 2'b00); tick();
      drive(0, 0, 1, 1, 2'b01, 2'b11);
      checks++;
      if (ready0 !== 1'b0 || ready1 !== 1'b1) begin
         failures++;
         $display("FAIL tie_after_src0: got r0=%b r1=%b want 0 1", ready0, ready1);
      end
      tick();
   endtask

   task automatic test_pause();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 1, 1, 2'b01, 2'b10); tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 1, 1, 2'b11, 2'b11);
         checks++;
         if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
            failures++;
            $display("FAIL pause_ready[%0d]: got r0=%b r1=%b want 0 0", k, ready0, ready1);
         end
         tick();
         checks++;
         if (data_out !== 2'b01 || valid_out !== 1'b1 || selector !== 1'b0) begin
            failures++;
            $display("FAIL pause_frozen[%0d]: got d=%b v=%b s=%b want 01 1 0", k, data_out, valid_out, selector);
         end
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 1, 2'b01, 2'b10);
         checks++;
         if (ready0 !== (k < 2) || ready1 !== (k == 2)) begin
            failures++;
            $display("FAIL pause_resume[%0d]: got r0=%b r1=%b want %b %b", k, ready0, ready1, k < 2, k == 2);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 1, 2'b00, 2'b11); tick();
      end
      drive(1, 0, 1, 1, 2'b10, 2'b11);
      checks++;
      if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_ready: got r0=%b r1=%b want 0 0", ready0, ready1);
      end
      tick();
      checks++;
      if (data_out !== 2'b00 || valid_out !== 1'b0 || selector !== 1'b0) begin
         failures++;
         $display("FAIL midreset_out: got d=%b v=%b s=%b want 00 0 0", data_out, valid_out, selector);
      end
      drive(0, 0, 1, 1, 2'b10, 2'b11);
      checks++;
      if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_first: got r0=%b r1=%b want 1 0", ready0, ready1);
      end
      tick();
      checks++;
      if (selector !== 1'b0 || data_out !== 2'b10 || valid_out !== 1'b1) begin
         failures++;
         $display("FAIL midreset_first_out: got s=%b d=%b v=%b want 0 10 1", selector, data_out, valid_out);
      end
   endtask

   task automatic test_random();
      logic r, p, v0, v1;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         r  = ($urandom_range(0, 99) < 3);
         p  = ($urandom_range(0, 99) < 15);
         v0 = ($urandom_range(0, 99) < 70);
         v1 = ($urandom_range(0, 99) < 70);
         drive(r, p, v0, v1, DW'($urandom), DW'($urandom));
         checks++;
         if (ready0 !== exp_r0 || ready1 !== exp_r1) begin
            failures++;
            $display("FAIL rand_ready[%0d]: got r0=%b r1=%b want %b %b", k, ready0, ready1, exp_r0, exp_r1);
         end
         tick();
         checks++;
         if (data_out !== m_dout || valid_out !== m_vout || selector !== m_sel) begin
            failures++;
            $display("FAIL rand_out[%0d]: got d=%b v=%b s=%b want d=%b v=%b s=%b",
                     k, data_out, valid_out, selector, m_dout, m_vout, m_sel);
         end
      end
   endtask

   initial begin
      reset = 1'b1; pause = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0;
      data_in0 = '0; data_in1 = '0;
      m_owner = -1; m_run = 0; m_last = 1; m_g = -1;
      m_dout = '0; m_vout = 1'b0; m_sel = 1'b0; exp_r0 = 1'b0; exp_r1 = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_tie();
      test_pause();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
